// File: rtl/pin_mux_seq_pkg.sv
// Shared types and helpers for the pad multiplexer and its mode-change sequencer.
package pin_mux_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GUARD  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam int unsigned GPIO_SRC = 0;

    // Bit position of alternate source s (s >= 1), pad p, in the packed alt vectors.
    function automatic int unsigned alt_idx(input int unsigned s, input int unsigned p,
                                            input int unsigned pins);
        return (s - 1) * pins + p;
    endfunction

endpackage

// File: rtl/pin_mux_seq_if.sv
// Mode-change request handshake between a configuration master and the pin mux.
interface pin_mux_seq_if #(
    parameter int unsigned PINS     = 32,
    parameter int unsigned SRC_BITS = 2
);
    localparam int unsigned PW = (PINS > 1) ? $clog2(PINS) : 1;

    logic                iCFG_WE;
    logic [PW-1:0]       iCFG_PIN;
    logic [SRC_BITS-1:0] iCFG_MSEL;
    logic                oCFG_READY;

    modport master (
        output iCFG_WE,
        output iCFG_PIN,
        output iCFG_MSEL,
        input  oCFG_READY
    );

    modport slave (
        input  iCFG_WE,
        input  iCFG_PIN,
        input  iCFG_MSEL,
        output oCFG_READY
    );

endinterface

// File: rtl/pin_mux_seq_sync.sv
// Single-pad input synchroniser with registered rising/falling edge detection.
module pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // r_prev sits outside the chain so a pad high at reset release yields one rise pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pin  = r_sync[SYNC_STAGES-1];
    assign o_rise = o_pin & ~r_prev;
    assign o_fall = ~o_pin & r_prev;

endmodule

// File: rtl/pin_mux_seq.sv
// Registered per-pad source multiplexer with break-before-make mode changes
// and synchronised, edge-detected pad inputs.
module pin_mux_seq
    import pin_mux_pkg::*;
#(
    parameter int unsigned PINS        = 32,
    parameter int unsigned SRC_BITS    = 2,
    parameter int unsigned GUARD       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                  iCLK,
    input  logic                                  iRESET,
    pin_mux_seq_if.slave                          cfg,
    input  logic [PINS-1:0]                       iGPIO_OUT,
    input  logic [PINS-1:0]                       iGPIO_DIR,
    input  logic [((1 << SRC_BITS) - 1)*PINS-1:0] iALT_OUT,
    input  logic [((1 << SRC_BITS) - 1)*PINS-1:0] iALT_OE,
    input  logic [PINS-1:0]                       iPIN_IN,
    output logic [PINS-1:0]                       oPIN_OUT,
    output logic [PINS-1:0]                       oPIN_OE,
    output logic [PINS-1:0]                       oPIN_IN,
    output logic [PINS-1:0]                       oPIN_RISE,
    output logic [PINS-1:0]                       oPIN_FALL,
    output logic [PINS*SRC_BITS-1:0]              oMSEL
);

    localparam int unsigned NSRC = 1 << SRC_BITS;
    localparam int unsigned PW   = (PINS > 1) ? $clog2(PINS) : 1;
    localparam int unsigned CW   = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CW-1:0] GUARD_INIT = CW'(GUARD - 1);

    state_t                             r_state;
    state_t                             w_next;
    logic [CW-1:0]                      r_cnt;
    logic [PW-1:0]                      r_pin;
    logic [SRC_BITS-1:0]                r_new_msel;
    logic [PINS-1:0][SRC_BITS-1:0]      r_msel;
    logic [PINS-1:0]                    r_pin_oe;
    logic [PINS-1:0]                    r_pin_out;

    logic                               w_in_range;
    logic [SRC_BITS-1:0]                w_cur_msel;
    logic                               w_accept;
    logic                               w_load;
    logic                               w_commit;
    logic                               w_force;
    logic [NSRC-1:0][PINS-1:0]          w_src_oe;
    logic [NSRC-1:0][PINS-1:0]          w_src_out;
    logic [PINS-1:0]                    w_oe;
    logic [PINS-1:0]                    w_out;

    // Request qualification: in-range pad whose mode actually changes.
    assign w_in_range = 32'(cfg.iCFG_PIN) < PINS;
    assign w_cur_msel = w_in_range ? r_msel[cfg.iCFG_PIN] : '0;
    assign w_accept   = cfg.iCFG_WE && w_in_range && (cfg.iCFG_MSEL != w_cur_msel);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_GUARD;
            S_GUARD:  if (r_cnt == '0) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg.oCFG_READY = (r_state == S_IDLE);
        w_force        = (r_state != S_IDLE);
        w_load         = (r_state == S_IDLE) && w_accept;
        w_commit       = (r_state == S_COMMIT);
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_cnt      <= '0;
            r_pin      <= '0;
            r_new_msel <= '0;
            r_msel     <= '0;
        end else begin
            if (w_load) begin
                r_cnt      <= GUARD_INIT;
                r_pin      <= cfg.iCFG_PIN;
                r_new_msel <= cfg.iCFG_MSEL;
            end else if (r_state == S_GUARD) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_msel[r_pin] <= r_new_msel;
            end
        end
    end

    // Source table: GPIO occupies slot 0 so every pad reduces to one indexed select.
    assign w_src_oe[GPIO_SRC]  = iGPIO_DIR;
    assign w_src_out[GPIO_SRC] = iGPIO_OUT;

    for (genvar s = 1; s < NSRC; s++) begin : g_src
        assign w_src_oe[s]  = iALT_OE[alt_idx(s, 0, PINS) +: PINS];
        assign w_src_out[s] = iALT_OUT[alt_idx(s, 0, PINS) +: PINS];
    end

    for (genvar p = 0; p < PINS; p++) begin : g_pad
        logic w_hold;
        assign w_hold   = w_force && (r_pin == PW'(p));
        assign w_oe[p]  = w_src_oe[r_msel[p]][p] & ~w_hold;
        assign w_out[p] = w_src_out[r_msel[p]][p] & w_oe[p];
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_pin_oe  <= '0;
            r_pin_out <= '0;
        end else begin
            r_pin_oe  <= w_oe;
            r_pin_out <= w_out;
        end
    end

    assign oPIN_OE  = r_pin_oe;
    assign oPIN_OUT = r_pin_out;
    assign oMSEL    = r_msel;

    for (genvar g = 0; g < PINS; g++) begin : g_sync
        pin_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk (iCLK),
            .i_rst (iRESET),
            .i_pin (iPIN_IN[g]),
            .o_pin (oPIN_IN[g]),
            .o_rise(oPIN_RISE[g]),
            .o_fall(oPIN_FALL[g])
        );
    end

endmodule

// File: tb/tb_pin_mux_seq.sv
// Directed self-checking bench for pin_mux_seq: output mux, mode-change sequencing, input edges.
module tb_pin_mux_seq;

    localparam int unsigned PINS        = 24;
    localparam int unsigned SRC_BITS    = 2;
    localparam int unsigned GUARD       = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned NALT        = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [PINS-1:0]          gpio_out;
    logic [PINS-1:0]          gpio_dir;
    logic [NALT*PINS-1:0]     alt_out;
    logic [NALT*PINS-1:0]     alt_oe;
    logic [PINS-1:0]          pin_in;
    logic [PINS-1:0]          pin_out;
    logic [PINS-1:0]          pin_oe;
    logic [PINS-1:0]          pin_in_s;
    logic [PINS-1:0]          pin_rise;
    logic [PINS-1:0]          pin_fall;
    logic [PINS*SRC_BITS-1:0] msel;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pin_mux_seq_if #(.PINS(PINS), .SRC_BITS(SRC_BITS)) cfg_if ();

    pin_mux_seq #(
        .PINS       (PINS),
        .SRC_BITS   (SRC_BITS),
        .GUARD      (GUARD),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .iCLK     (clk),
        .iRESET   (rst),
        .cfg      (cfg_if),
        .iGPIO_OUT(gpio_out),
        .iGPIO_DIR(gpio_dir),
        .iALT_OUT (alt_out),
        .iALT_OE  (alt_oe),
        .iPIN_IN  (pin_in),
        .oPIN_OUT (pin_out),
        .oPIN_OE  (pin_oe),
        .oPIN_IN  (pin_in_s),
        .oPIN_RISE(pin_rise),
        .oPIN_FALL(pin_fall),
        .oMSEL    (msel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned n_rise;
        int unsigned n_fall;
        n_rise = 0;
        n_fall = 0;

        rst              = 1'b1;
        cfg_if.iCFG_WE   = 1'b0;
        cfg_if.iCFG_PIN  = '0;
        cfg_if.iCFG_MSEL = '0;
        gpio_out         = '0;
        gpio_dir         = '0;
        alt_out          = '0;
        alt_oe           = '0;
        pin_in           = '0;
        step();
        step();
        chk("rst_msel", msel, 0);
        chk("rst_oe", pin_oe, 0);
        chk("rst_out", pin_out, 0);
        chk("rst_ready", cfg_if.oCFG_READY, 1);
        chk("rst_rise", pin_rise, 0);
        chk("rst_fall", pin_fall, 0);
        rst = 1'b0;

        // GPIO path: pad 3 drives 1, pad 4 has a value but no enable.
        gpio_dir = 24'h000008;
        gpio_out = 24'h000018;
        step();
        chk("gpio_oe", pin_oe, 24'h000008);
        chk("gpio_out", pin_out, 24'h000008);

        // Pad 5 on GPIO drives 0; source 2 for pad 5 (bit 29) drives 1.
        gpio_dir    = 24'h000028;
        gpio_out    = 24'h000008;
        alt_oe[29]  = 1'b1;
        alt_out[29] = 1'b1;
        step();
        chk("pre_oe", pin_oe, 24'h000028);
        chk("pre_out", pin_out, 24'h000008);

        cfg_if.iCFG_WE   = 1'b1;
        cfg_if.iCFG_PIN  = 5'd5;
        cfg_if.iCFG_MSEL = 2'd2;
        step();
        cfg_if.iCFG_WE = 1'b0;
        chk("e0_ready", cfg_if.oCFG_READY, 0);
        chk("e0_oe", pin_oe, 24'h000028);

        // Attempted write while busy must be dropped.
        cfg_if.iCFG_WE   = 1'b1;
        cfg_if.iCFG_PIN  = 5'd7;
        cfg_if.iCFG_MSEL = 2'd1;
        step();
        cfg_if.iCFG_WE = 1'b0;
        chk("e1_ready", cfg_if.oCFG_READY, 0);
        chk("e1_oe", pin_oe, 24'h000008);
        chk("e1_out", pin_out, 24'h000008);
        chk("e1_msel", msel, 0);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("e%0d_ready", k), cfg_if.oCFG_READY, 0);
            chk($sformatf("e%0d_oe", k), pin_oe, 24'h000008);
            chk($sformatf("e%0d_msel", k), msel, 0);
        end
        step();
        chk("e5_ready", cfg_if.oCFG_READY, 1);
        chk("e5_msel", msel, 48'h000000000800);
        chk("e5_oe", pin_oe, 24'h000008);
        step();
        chk("e6_oe", pin_oe, 24'h000028);
        chk("e6_out", pin_out, 24'h000028);

        // Same-mode write is a no-op: no busy period, no gap.
        cfg_if.iCFG_WE   = 1'b1;
        cfg_if.iCFG_PIN  = 5'd5;
        cfg_if.iCFG_MSEL = 2'd2;
        step();
        cfg_if.iCFG_WE = 1'b0;
        chk("same_ready", cfg_if.oCFG_READY, 1);
        chk("same_oe", pin_oe, 24'h000028);
        step();
        chk("same_ready2", cfg_if.oCFG_READY, 1);
        chk("same_oe2", pin_oe, 24'h000028);

        // Pad index beyond PINS is ignored.
        cfg_if.iCFG_WE   = 1'b1;
        cfg_if.iCFG_PIN  = 5'd28;
        cfg_if.iCFG_MSEL = 2'd1;
        step();
        cfg_if.iCFG_WE = 1'b0;
        chk("oor_ready", cfg_if.oCFG_READY, 1);
        chk("oor_msel", msel, 48'h000000000800);
        step();
        chk("oor_ready2", cfg_if.oCFG_READY, 1);

        // Reset in the middle of a guard period on pad 7.
        alt_oe[7]  = 1'b1;
        alt_out[7] = 1'b1;
        cfg_if.iCFG_WE   = 1'b1;
        cfg_if.iCFG_PIN  = 5'd7;
        cfg_if.iCFG_MSEL = 2'd1;
        step();
        cfg_if.iCFG_WE = 1'b0;
        chk("abort_ready", cfg_if.oCFG_READY, 0);
        step();
        step();
        chk("abort_oe", pin_oe, 24'h000028);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_msel", msel, 0);
        chk("abort_oe0", pin_oe, 0);
        chk("abort_out0", pin_out, 0);
        chk("abort_rdy", cfg_if.oCFG_READY, 1);
        step();
        chk("post_oe", pin_oe, 24'h000028);
        chk("post_out", pin_out, 24'h000008);
        chk("post_msel", msel, 0);

        // Input path: pad 0 high for 5 edges, then low.
        pin_in[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk($sformatf("in_c%0d", c), pin_in_s[0], (c >= 2 && c <= 6) ? 1'b1 : 1'b0);
            chk($sformatf("rise_c%0d", c), pin_rise[0], (c == 2) ? 1'b1 : 1'b0);
            chk($sformatf("fall_c%0d", c), pin_fall[0], (c == 7) ? 1'b1 : 1'b0);
            n_rise += int'(pin_rise[0]);
            n_fall += int'(pin_fall[0]);
            if (c == 5) pin_in[0] = 1'b0;
        end
        chk("rise_count", n_rise, 1);
        chk("fall_count", n_fall, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
